adder_share_arb: RTL and testbench
==================================

Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one instance of the team's combinational 12-bit prefix adder between NREQ requesters.
- Each requester presents an operand pair on a valid/ready handshake.
- The arbiter grants one request per cycle, drives the adder and registers the 13-bit sum into a one-deep output stage with backpressure.
- Tagged with the winning requester index, so downstream logic can route the result.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, width of the source tag; must equal ceil(log2(NREQ)), minimum 1.
- RR_EN_DEFAULT, 1, arbitration policy after reset: 1 = round-robin, 0 = fixed priority (index 0 highest).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rr_mode  in  1  policy select: 1 = round-robin, 0 = fixed priority; sampled every cycle; ignored until first cycle after reset release (RR_EN_DEFAULT applies in reset).
- req_valid  in  NREQ  request valid per requester.
- req_ready  out  NREQ  one-hot grant/accept; bit i high only in the cycle requester i's operands are captured.
- req_a  in  NREQ*12  operand A, requester i at bits [12i+11:12i].
- req_b  in  NREQ*12  operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_sum  out  13  A+B, bit 12 = carry out.
- rsp_src  out  IDW  index of requester that produced rsp_sum.
- busy  out  1  high while rsp_valid or any req_valid is high.

Behaviour:
- Reset (async, rst_n low):
  - rsp_valid=0, rsp_sum=0, rsp_src=0, req_ready=0.
  - Round-robin pointer=0; policy register=RR_EN_DEFAULT.
- Adder hookup:
  - Operand bit k of A drives adder input 2k; bit k of B drives input 2k+1.
  - The 13-bit adder output maps directly to rsp_sum.
  - The adder has no carry-in; none is added.
- Output stage has two states, EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = EMPTY, or FULL with rsp_ready=1 in the same cycle.
- Arbitration when can_accept and |req_valid:
  - Round-robin: winner is the first i with req_valid[i], searching from ptr upward with wrap at NREQ-1 -> 0.
  - Fixed priority: winner is the lowest set index.
  - req_ready[winner]=1 combinationally in that cycle.
- Capture:
  - On the next edge, rsp_sum <= A[w]+B[w], rsp_src <= w, rsp_valid <= 1.
  - Round-robin only: ptr <= (w+1) mod NREQ.
  - Fixed priority leaves ptr unchanged.
- Latency: accepted in cycle N -> rsp_valid with the sum in cycle N+1.
- Throughput: 1 result/cycle when rsp_ready is held high.
- Stall:
  - FULL and rsp_ready=0: all req_ready=0; rsp_sum/rsp_src held stable; ptr held.
  - Requesters must keep valid and operands stable until ready; req_ready never depends on requests that are not the winner.
- Drain: FULL, rsp_ready=1, no req_valid -> next state EMPTY, rsp_valid=0; rsp_sum/rsp_src keep their last values.
- Simultaneous: FULL, rsp_ready=1, a request present -> old result retires and the new one is captured on the same edge (no bubble).
- rr_mode change mid-stream takes effect on the next arbitration. ptr is retained, so round-robin resumes from the stored ptr.
- Fairness: in round-robin with all requesters valid and rsp_ready=1, grants follow 0,1,..,NREQ-1,0,...
- Reset mid-operation: any pending result is discarded; no handshake completes in the reset cycle.
- rsp_valid never drops without rsp_ready.

Optional Feature:
- Macro ADDER_SHARE_PERF_EN.
- When defined, add outputs:
  - perf_ops (32 bits): count of accepted requests.
  - perf_stall (32 bits): count of cycles with FULL, rsp_ready=0 and |req_valid.
  - perf_clr (input, 1 bit): synchronous clear; clear wins over increment in the same cycle.
- Both counters saturate at 0xFFFFFFFF and reset to 0 on rst_n.
- When not defined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset, then req0 A=0xFFF B=0x001 with rsp_ready=1 -> req_ready=0001 in cycle 0; cycle 1 rsp_valid=1, rsp_sum=0x1000, rsp_src=0.
- All 4 valid, rr_mode=1, rsp_ready=1, A=i, B=0x100 -> rsp_src sequence 0,1,2,3,0; rsp_sum=0x100+i; one result per cycle.
- Same stimulus with rr_mode=0 -> rsp_src=0 every cycle; req_ready only ever 0001.
- FULL with rsp_ready=0 for 5 cycles, req2 valid -> req_ready=0 throughout and rsp_sum unchanged; rsp_ready=1 -> req2 granted that cycle, rsp_src=2 next cycle.
- Assert rst_n=0 asynchronously mid-stream while FULL -> rsp_valid=0 immediately; after release, grant order restarts from requester 0.
- With ADDER_SHARE_PERF_EN: 10 accepts plus 3 stall cycles -> perf_ops=10, perf_stall=3; perf_clr asserted for one cycle -> both read 0 the next cycle.

Source files
------------

// File: rtl/adder_share_arb.sv
// Shares one 12-bit prefix adder between NREQ requesters (round-robin or fixed priority); optional perf counters under ADDER_SHARE_PERF_EN.
// Latency: request granted in cycle N -> tagged 13-bit sum on rsp_* in cycle N+1; one result per cycle.
// Backpressure: one-deep output stage; while full and rsp_ready low no request is granted and the result holds.

// Combinational 12-bit Kogge-Stone adder with bit-interleaved operands (A[k] at 2k, B[k] at 2k+1).
// Latency: combinational.
// Backpressure: none.
module prefix_add12 (
    input  logic [23:0] opnd,
    output logic [12:0] sum
);
    logic [11:0] a, b, p, g, pp, gg, pn, gn;

    always_comb begin
        a  = '0;
        b  = '0;
        for (int k = 0; k < 12; k++) begin
            a[k] = opnd[2*k];
            b[k] = opnd[2*k+1];
        end
        p  = a ^ b;
        g  = a & b;
        pp = p;
        gg = g;
        pn = p;
        gn = g;
        for (int l = 0; l < 4; l++) begin
            pn = pp;
            gn = gg;
            for (int i = (1 << l); i < 12; i++) begin
                gn[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pn[i] = pp[i] & pp[i - (1 << l)];
            end
            pp = pn;
            gg = gn;
        end
        // gg[i] is now the carry out of bit i
        sum = {gg[11], p ^ {gg[10:0], 1'b0}};
    end
endmodule

module adder_share_arb #(
    parameter int NREQ          = 4,
    parameter int IDW           = 2,
    parameter bit RR_EN_DEFAULT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rr_mode,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*12-1:0] req_a,
    input  logic [NREQ*12-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [12:0]        rsp_sum,
    output logic [IDW-1:0]     rsp_src,
`ifdef ADDER_SHARE_PERF_EN
    input  logic               perf_clr,
    output logic [31:0]        perf_ops,
    output logic [31:0]        perf_stall,
`endif
    output logic               busy
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, win, src_q;
    logic           rr_q, any_vld, can_accept, grant;
    logic [11:0]    a_sel, b_sel;
    logic [23:0]    add_in;
    logic [12:0]    add_sum, sum_q;
    int             idx;

    // Descending scan so the candidate closest to the search start is written last.
    always_comb begin : arb
        win     = '0;
        idx     = 0;
        any_vld = |req_valid;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = rr_q ? int'(ptr_q) + k : k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) win = IDW'(idx);
        end
    end

    always_comb begin : opsel
        a_sel  = '0;
        b_sel  = '0;
        add_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                a_sel = req_a[12*i +: 12];
                b_sel = req_b[12*i +: 12];
            end
        end
        for (int k = 0; k < 12; k++) begin
            add_in[2*k]   = a_sel[k];
            add_in[2*k+1] = b_sel[k];
        end
    end

    prefix_add12 u_add (
        .opnd (add_in),
        .sum  (add_sum)
    );

    // rst_n gates the grant so no handshake can complete while reset is held.
    always_comb begin : fsm
        state_d    = state_q;
        req_ready  = '0;
        can_accept = (state_q == EMPTY) || rsp_ready;
        grant      = rst_n && can_accept && any_vld;
        if (grant) begin
            state_d        = FULL;
            req_ready[win] = 1'b1;
        end else if (rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            rr_q    <= RR_EN_DEFAULT;
            sum_q   <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_mode;
            if (grant) begin
                sum_q <= add_sum;
                src_q <= win;
                if (rr_q) ptr_q <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_sum   = sum_q;
    assign rsp_src   = src_q;
    assign busy      = rsp_valid | any_vld;

`ifdef ADDER_SHARE_PERF_EN
    logic [31:0] ops_q, stall_q;
    logic        stall;

    assign stall = (state_q == FULL) && !rsp_ready && any_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q   <= '0;
            stall_q <= '0;
        end else if (perf_clr) begin
            ops_q   <= '0;
            stall_q <= '0;
        end else begin
            if (grant && (ops_q != '1)) ops_q <= ops_q + 32'd1;
            if (stall && (stall_q != '1)) stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_ops   = ops_q;
    assign perf_stall = stall_q;
`endif
endmodule

// File: tb/tb_adder_share_arb.sv
// Randomized and directed bench for adder_share_arb: a reference model predicts grants and results,
// a monitor retires results from a scoreboard queue at each output handshake.
module tb_adder_share_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam bit RR_DEF = 1'b1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               rr_mode = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*12-1:0] req_a = '0;
    logic [NREQ*12-1:0] req_b = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [12:0]        rsp_sum;
    logic [IDW-1:0]     rsp_src;
    logic               busy;
`ifdef ADDER_SHARE_PERF_EN
    logic               perf_clr = 1'b0;
    logic [31:0]        perf_ops, perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    logic [IDW+12:0] exp_q[$];

    adder_share_arb #(.NREQ(NREQ), .IDW(IDW), .RR_EN_DEFAULT(RR_DEF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rr_mode   (rr_mode),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_src   (rsp_src),
`ifdef ADDER_SHARE_PERF_EN
        .perf_clr  (perf_clr),
        .perf_ops  (perf_ops),
        .perf_stall(perf_stall),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: output stage occupancy, pointer and the policy seen by this cycle's arbitration.
    bit              m_full = 1'b0;
    bit              m_rr   = RR_DEF;
    int              m_ptr  = 0;
    int              w, c;
    logic [NREQ-1:0] exp_rdy;
    logic [12:0]     esum;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_full = 1'b0;
            m_ptr  = 0;
            m_rr   = RR_DEF;
            exp_q.delete();
            check("reset_req_ready", req_ready, 0);
            check("reset_rsp_valid", rsp_valid, 0);
        end else begin
            w       = -1;
            c       = 0;
            exp_rdy = '0;
            if (!m_full || rsp_ready) begin
                for (int k = 0; k < NREQ; k++) begin
                    c = m_rr ? (m_ptr + k) % NREQ : k;
                    if (w < 0 && req_valid[c]) w = c;
                end
            end
            check("model_rsp_valid", rsp_valid, m_full);
            if (w >= 0) exp_rdy[w] = 1'b1;
            check("model_req_ready", req_ready, exp_rdy);
            if (w >= 0) begin
                esum = 13'(req_a[12*w +: 12]) + 13'(req_b[12*w +: 12]);
                exp_q.push_back({IDW'(w), esum});
                if (m_rr) m_ptr = (w + 1) % NREQ;
                m_full = 1'b1;
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
            m_rr = rr_mode;
        end
    end

    logic [IDW+12:0] mon_e;
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_underflow: result src=%0d sum=0x%0h with nothing expected", rsp_src, rsp_sum);
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_rsp_src", rsp_src, mon_e[IDW+12:13]);
                check("mon_rsp_sum", rsp_sum, mon_e[12:0]);
            end
        end
    end

    logic [NREQ-1:0] hs;

    initial begin
        // Reset state, then carry-out case on requester 0
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_rsp_src", rsp_src, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n            = 1'b1;
        req_a[11:0]      = 12'hFFF;
        req_b[11:0]      = 12'h001;
        req_valid        = 4'b0001;
        rsp_ready        = 1'b1;
        @(negedge clk);
        check("t1_req_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_sum", rsp_sum, 13'h1000);
        check("t1_rsp_src", rsp_src, 0);
        tick();

        // Round-robin fairness with all requesters valid
        do_reset();
        rr_mode   = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[12*i +: 12] = 12'(i);
            req_b[12*i +: 12] = 12'h100;
        end
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 5) check("rr_req_ready", req_ready, 32'(1) << (k % NREQ));
            if (k > 0) begin
                check("rr_rsp_valid", rsp_valid, 1);
                check("rr_rsp_src", rsp_src, (k - 1) % NREQ);
                check("rr_rsp_sum", rsp_sum, 32'h100 + ((k - 1) % NREQ));
            end
            tick();
        end

        // Fixed priority: requester 0 always wins
        req_valid = '0;
        rr_mode   = 1'b0;
        tick();
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("fp_req_ready", req_ready, 4'b0001);
            if (k > 0) check("fp_rsp_src", rsp_src, 0);
            tick();
        end
        req_valid = '0;
        rr_mode   = 1'b1;
        tick();

        // Stall with rsp_ready low, then release
        req_a[11:0] = 12'h123;
        req_b[11:0] = 12'h045;
        req_valid   = 4'b0001;
        rsp_ready   = 1'b1;
        tick();
        req_a[35:24] = 12'h200;
        req_b[35:24] = 12'h00F;
        req_valid    = 4'b0100;
        rsp_ready    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_req_ready", req_ready, 0);
            check("stall_rsp_sum", rsp_sum, 13'h168);
            check("stall_rsp_valid", rsp_valid, 1);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("stall_release_src", rsp_src, 2);
        check("stall_release_sum", rsp_sum, 13'h20F);
        tick();

        // Asynchronous reset while full, then order restarts at requester 0
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        tick();
        req_valid = '0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rr_mode   = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '1;
        @(negedge clk);
        check("post_rst_grant0", req_ready, 4'b0001);
        tick();
        @(negedge clk);
        check("post_rst_grant1", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        tick();

`ifdef ADDER_SHARE_PERF_EN
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        @(negedge clk);
        check("perf_start_ops", perf_ops, 0);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        repeat (10) tick();
        rsp_ready = 1'b0;
        repeat (3) tick();
        req_valid = '0;
        @(negedge clk);
        check("perf_ops_10", perf_ops, 10);
        check("perf_stall_3", perf_stall, 3);
        rsp_ready = 1'b1;
        tick();
        perf_clr  = 1'b1;
        req_valid = 4'b0001;
        tick();
        perf_clr  = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("perf_clr_ops", perf_ops, 0);
        check("perf_clr_stall", perf_stall, 0);
        tick();
`endif

        // Randomized traffic with protocol-respecting requesters
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            hs = req_ready;
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || hs[i]) begin
                    req_valid[i]      = ($urandom_range(0, 99) < 55);
                    req_a[12*i +: 12] = 12'($urandom);
                    req_b[12*i +: 12] = 12'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 3) rr_mode = ~rr_mode;
        end

        // Drain
        @(negedge clk);
        hs = req_ready;
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_busy", busy, 0);
        check("drain_rsp_valid", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
